// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit for the execute stage: shift-add multiplier and restoring
// divider sharing one double-width accumulator, sequenced by a small FSM that stalls EX.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic [XLEN-1:0] Result,
  output logic            Busy,
  output logic            Done,
  output logic            Stall
);

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   opb_r;
  logic [2*XLEN-1:0] acc_r;
  logic              neg_r;

  logic              sgn_a_s;
  logic              sgn_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              neg_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic [XLEN-1:0]   special_s;
  logic [XLEN:0]     add_s;
  logic [XLEN:0]     shift_s;
  logic [XLEN:0]     diff_s;
  logic [2*XLEN-1:0] step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_rem_s;
  logic [XLEN-1:0]   final_s;

  // Operand decode: magnitudes, result sign and the cases that skip iteration
  always_comb begin
    sgn_a_s = ((Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
               (Funct3 == OP_DIV)  || (Funct3 == OP_REM)) && SrcA[XLEN-1];
    sgn_b_s = ((Funct3 == OP_MULH) || (Funct3 == OP_DIV) ||
               (Funct3 == OP_REM)) && SrcB[XLEN-1];
    mag_a_s = sgn_a_s ? -SrcA : SrcA;
    mag_b_s = sgn_b_s ? -SrcB : SrcB;
    // A remainder follows the dividend's sign only
    neg_s   = (Funct3 == OP_REM) ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
    div_zero_s = Funct3[2] && (SrcB == '0);
    div_ovf_s  = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
                 (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    if (div_zero_s) begin
      special_s = Funct3[1] ? SrcA : '1;
    end else if (div_ovf_s) begin
      special_s = Funct3[1] ? '0 : SrcA;
    end else begin
      special_s = '0;
    end
  end

  // One iteration of the active algorithm plus the sign-corrected final result
  always_comb begin
    add_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : '0);
    shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    diff_s  = shift_s - {1'b0, opb_r};
    // Upper half holds the partial remainder, lower half shifts dividend out and quotient in
    if (op_r[2]) begin
      if (diff_s[XLEN]) begin
        step_s = {shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end else begin
        step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end
    end else begin
      step_s = {add_s, acc_r[XLEN-1:1]};
    end
    prod_s     = neg_r ? -step_s : step_s;
    quot_rem_s = op_r[1] ? step_s[2*XLEN-1:XLEN] : step_s[XLEN-1:0];
    if (op_r[2]) begin
      final_s = neg_r ? -quot_rem_s : quot_rem_s;
    end else if (op_r[1:0] == 2'b00) begin
      final_s = prod_s[XLEN-1:0];
    end else begin
      final_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Sequencer FSM with datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      op_r    <= 3'b000;
      opb_r   <= '0;
      acc_r   <= '0;
      neg_r   <= 1'b0;
      Result  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          Done <= 1'b0;
          if (Start && !Flush) begin
            op_r  <= Funct3;
            opb_r <= mag_b_s;
            neg_r <= neg_s;
            cnt_r <= '0;
            acc_r <= {{XLEN{1'b0}}, mag_a_s};
            Busy  <= 1'b1;
            if (div_zero_s || div_ovf_s) begin
              state_r <= DONE;
              Done    <= 1'b1;
              Result  <= special_s;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (Flush) begin
            state_r <= IDLE;
            Busy    <= 1'b0;
            cnt_r   <= '0;
          end else begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(XLEN-1)) begin
              state_r <= DONE;
              Done    <= 1'b1;
              Result  <= final_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

  assign Stall = (Busy || (Start && (state_r == IDLE))) && !Done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, flush/reset behaviour,
// and random operations checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic [31:0] Result;
  logic        Busy;
  logic        Done;
  logic        Stall;

  int          n_chk;
  int          n_pass;
  logic [31:0] exp_last;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Result(Result), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 32'd0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called just after a clock edge; lat counts edges from the edge after Start is driven
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input bit noise);
    int edges;
    int stalls;
    bit seen;
    Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
    edges = 0; stalls = 0; seen = 1'b0;
    while (!seen && edges < 40) begin
      #1;
      if (Stall) stalls++;
      @(posedge clk); #1;
      edges++;
      if (Done) seen = 1'b1;
      else begin
        Start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        SrcA   = $urandom;
        SrcB   = $urandom;
        Funct3 = 3'($urandom_range(0, 7));
      end
    end
    Start = 1'b0;
    chk({tag, " done"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, edges, exp_lat);
    chk({tag, " result"}, Result, exp_res);
    chk({tag, " stall_cycles"}, stalls, exp_lat);
    chk({tag, " stall_in_done"}, 32'(Stall), 32'd0);
    exp_last = exp_res;
    @(posedge clk); #1;
    chk({tag, " back_to_idle"}, {Busy, Done}, 32'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          dones;
    n_chk = 0; n_pass = 0; exp_last = 32'd0;
    reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    #12;
    chk("reset result", Result, 32'd0);
    chk("reset busy_done_stall", {Busy, Done, Stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7x-3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulh",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
    run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_-7/2",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_-7/2",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_100/7", 3'd5, 32'd100,        32'd7,         32'd14,        33, 1'b0);
    run_op("remu_100/7", 3'd7, 32'd100,        32'd7,         32'd2,         33, 1'b0);
    run_op("divu_by0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("rem_by0",    3'd6, 32'd5,          32'd0,         32'd5,         1,  1'b0);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    run_op("start_noise", 3'd0, 32'd123456,   32'd654321,    ref_op(3'd0, 32'd123456, 32'd654321), 33, 1'b1);

    // Flush partway through a multiply: no Done and Result untouched
    Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #1; Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    chk("flush busy_done", {Busy, Done}, 32'd0);
    chk("flush result_kept", Result, exp_last);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) dones++;
    end
    chk("flush no_done", dones, 32'd0);

    // Start together with Flush in IDLE is ignored
    Start = 1'b1; Flush = 1'b1; Funct3 = 3'd5; SrcA = 32'd8; SrcB = 32'd2;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    chk("flush_start busy", 32'(Busy), 32'd0);
    run_op("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 33, 1'b0);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_op(f, a, b), ref_lat(f, a, b), 1'b1);
    end

    // Asynchronous reset between edges in the middle of RUN
    Funct3 = 3'd3; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #3; reset = 1'b1;
    #1;
    chk("async_reset busy_done", {Busy, Done}, 32'd0);
    chk("async_reset result", Result, 32'd0);
    #3; reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset idle", 32'(Busy), 32'd0);
    run_op("post_reset_rem", 3'd6, 32'd17, 32'hFFFF_FFFB, 32'd2, 33, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
